amiga_video_mode_detect: RTL and testbench

// Upstream of the Analogue video encoder: measures raw Amiga sync/blank timing on the pixel clock domain and

---
 rtl/amiga_video_mode_detect_pkg.sv | 29 ++
 rtl/amiga_sync_edge.sv | 27 ++
 rtl/amiga_video_mode_detect.sv | 213 +++++++++++++++++++++
 tb/tb_amiga_video_mode_detect.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/amiga_video_mode_detect_pkg.sv
// Shared encodings and helpers for the Amiga video mode detector.
// Resolution codes match what the downstream encoder expects on res[1:0].
package amiga_video_mode_detect_pkg;

  localparam logic [1:0] RES_LORES = 2'd0;
  localparam logic [1:0] RES_HIRES = 2'd1;
  localparam logic [1:0] RES_SHRES = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } mode_state_e;

  typedef struct packed {
    logic       lace;
    logic [1:0] res;
  } mode_cand_t;

  // Active pixel count per line -> resolution class.
  function automatic logic [1:0] classify_res(input int unsigned act,
                                              input int unsigned lores_max,
                                              input int unsigned hires_max);
    if (act <= lores_max) return RES_LORES;
    if (act <= hires_max) return RES_HIRES;
    return RES_SHRES;
  endfunction

endpackage

// File: rtl/amiga_sync_edge.sv
// Single-register capture of a raw sync/blank input with rise/fall pulses
// decoded from the registered copy.
module amiga_sync_edge (
  input  logic video_rgb_clock,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic q;
  logic q_d;

  always_ff @(posedge video_rgb_clock) begin
    if (reset) begin
      q   <= 1'b0;
      q_d <= 1'b0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  end

  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/amiga_video_mode_detect.sv
// Measures Amiga sync/blank timing and publishes field1/lace/res plus frame
// geometry, updated only at the vs falling edge.
//
// state   | meaning
// IDLE    | no vertical lock; waiting for the first vs falling edge
// ACQUIRE | frames seen, waiting for a stable classification
// LOCKED  | outputs valid; geometry refreshed every frame
module amiga_video_mode_detect #(
  parameter int CNT_W         = 12,
  parameter int LORES_MAX     = 400,
  parameter int HIRES_MAX     = 800,
  parameter int STABLE_FRAMES = 2,
  parameter int VS_TIMEOUT    = 1023
) (
  input  logic             video_rgb_clock,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             hs,
  input  logic             vs,
  input  logic             hblank,
  input  logic             vblank,
  output logic             field1,
  output logic             lace,
  output logic [1:0]       res,
  output logic [CNT_W-1:0] active_pixels,
  output logic [CNT_W-1:0] active_lines,
  output logic             mode_valid,
  output logic             mode_change
);

  import amiga_video_mode_detect_pkg::*;

  localparam int               STAB_W   = $clog2(STABLE_FRAMES + 1) + 1;
  localparam logic [STAB_W-1:0] STAB_REQ = STAB_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0]  TO_LIMIT = CNT_W'(VS_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic hs_fall, vs_fall;
  logic hs_rise, vs_rise;
  logic edge_unused;

  amiga_sync_edge u_hs_edge (
    .video_rgb_clock (video_rgb_clock),
    .reset           (reset),
    .d               (hs),
    .rise            (hs_rise),
    .fall            (hs_fall)
  );

  amiga_sync_edge u_vs_edge (
    .video_rgb_clock (video_rgb_clock),
    .reset           (reset),
    .d               (vs),
    .rise            (vs_rise),
    .fall            (vs_fall)
  );

  assign edge_unused = hs_rise ^ vs_rise;

  // ce_pix is delayed with the blanks so the active window stays aligned.
  logic hblank_r, vblank_r, ce_r;

  logic [CNT_W-1:0]  line_pix, line_len, act_cnt, act_last, line_act_cnt, to_cnt;
  logic [CNT_W-1:0]  act_last_nxt, line_act_nxt, to_nxt, phase;
  logic              parity, prev_parity, lace_cand, timeout_hit, stab_ok;
  logic [1:0]        res_cand;
  mode_cand_t        cand_q, cand_nxt;
  logic [STAB_W-1:0] stab_cnt, stab_nxt;

  mode_state_e state_q, state_d;
  logic        load_all, load_frame, load_mode;

  always_comb begin
    act_last_nxt = act_last;
    line_act_nxt = line_act_cnt;
    if (hs_fall && (act_cnt != '0)) begin
      act_last_nxt = act_cnt;
      line_act_nxt = sat_inc(line_act_cnt);
    end

    phase  = hs_fall ? '0 : line_pix;
    parity = hs_fall ? 1'b0 : (phase >= (line_len >> 1));

    lace_cand = parity ^ prev_parity;
    res_cand  = (act_last_nxt != '0) ?
                classify_res(32'(act_last_nxt), LORES_MAX, HIRES_MAX) : cand_q.res;
    cand_nxt  = '{lace: lace_cand, res: res_cand};

    if (cand_nxt == cand_q)
      stab_nxt = (stab_cnt == '1) ? stab_cnt : stab_cnt + 1'b1;
    else
      stab_nxt = STAB_W'(1);
    stab_ok = (stab_nxt >= STAB_REQ);

    to_nxt      = sat_inc(to_cnt);
    timeout_hit = hs_fall & ~vs_fall & (to_nxt >= TO_LIMIT);
  end

  always_ff @(posedge video_rgb_clock) begin
    if (reset) begin
      hblank_r     <= 1'b0;
      vblank_r     <= 1'b0;
      ce_r         <= 1'b0;
      line_pix     <= '0;
      line_len     <= '0;
      act_cnt      <= '0;
      act_last     <= '0;
      line_act_cnt <= '0;
      to_cnt       <= '0;
      prev_parity  <= 1'b0;
      cand_q       <= '0;
      stab_cnt     <= '0;
    end else begin
      hblank_r <= hblank;
      vblank_r <= vblank;
      ce_r     <= ce_pix;

      if (hs_fall) begin
        line_pix <= CNT_W'(1);
        line_len <= line_pix;
        act_cnt  <= '0;
      end else begin
        line_pix <= sat_inc(line_pix);
        if (ce_r && !hblank_r && !vblank_r)
          act_cnt <= sat_inc(act_cnt);
      end

      act_last     <= act_last_nxt;
      line_act_cnt <= vs_fall ? '0 : line_act_nxt;

      if (vs_fall)
        to_cnt <= '0;
      else if (hs_fall)
        to_cnt <= to_nxt;

      if (vs_fall) begin
        prev_parity <= parity;
        cand_q      <= cand_nxt;
        stab_cnt    <= stab_nxt;
      end
    end
  end

  always_ff @(posedge video_rgb_clock) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    load_all   = 1'b0;
    load_frame = 1'b0;
    load_mode  = 1'b0;
    case (state_q)
      IDLE: begin
        if (vs_fall)
          state_d = ACQUIRE;
      end
      ACQUIRE: begin
        if (vs_fall && stab_ok) begin
          state_d  = LOCKED;
          load_all = 1'b1;
        end
      end
      LOCKED: begin
        if (vs_fall) begin
          load_frame = 1'b1;
          if (stab_ok && (cand_nxt != {lace, res}))
            load_mode = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // timeout_hit never coincides with vs_fall, so no load is pending here
    if (timeout_hit)
      state_d = IDLE;
  end

  always_ff @(posedge video_rgb_clock) begin
    if (reset) begin
      field1        <= 1'b0;
      lace          <= 1'b0;
      res           <= RES_LORES;
      active_pixels <= '0;
      active_lines  <= '0;
      mode_valid    <= 1'b0;
      mode_change   <= 1'b0;
    end else begin
      mode_change <= 1'b0;
      if (load_all || load_frame) begin
        field1        <= parity;
        active_pixels <= act_last_nxt;
        active_lines  <= line_act_nxt;
      end
      if (load_all || load_mode) begin
        lace        <= cand_nxt.lace;
        res         <= cand_nxt.res;
        mode_change <= 1'b1;
      end
      if (load_all)
        mode_valid <= 1'b1;
      else if (timeout_hit)
        mode_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_amiga_video_mode_detect.sv
// Randomized line/frame stimulus against a frame-level reference model of
// the mode detector, using scaled-down thresholds to keep runs short.
module tb_amiga_video_mode_detect;

  localparam int CNT_W         = 12;
  localparam int LORES_MAX     = 40;
  localparam int HIRES_MAX     = 80;
  localparam int STABLE_FRAMES = 2;
  localparam int VS_TIMEOUT    = 31;
  localparam int HS_W          = 8;
  localparam int HB_END        = 24;
  localparam int VB_LINES      = 4;
  localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2;

  logic             video_rgb_clock = 1'b0;
  logic             reset  = 1'b1;
  logic             ce_pix = 1'b0;
  logic             hs     = 1'b1;
  logic             vs     = 1'b0;
  logic             hblank = 1'b1;
  logic             vblank = 1'b1;
  logic             field1, lace, mode_valid, mode_change;
  logic [1:0]       res;
  logic [CNT_W-1:0] active_pixels, active_lines;

  amiga_video_mode_detect #(
    .CNT_W(CNT_W), .LORES_MAX(LORES_MAX), .HIRES_MAX(HIRES_MAX),
    .STABLE_FRAMES(STABLE_FRAMES), .VS_TIMEOUT(VS_TIMEOUT)
  ) dut (
    .video_rgb_clock (video_rgb_clock),
    .reset           (reset),
    .ce_pix          (ce_pix),
    .hs              (hs),
    .vs              (vs),
    .hblank          (hblank),
    .vblank          (vblank),
    .field1          (field1),
    .lace            (lace),
    .res             (res),
    .active_pixels   (active_pixels),
    .active_lines    (active_lines),
    .mode_valid      (mode_valid),
    .mode_change     (mode_change)
  );

  always #5 video_rgb_clock = ~video_rgb_clock;

  int n_checks = 0;
  int n_fail   = 0;
  int mc_seen  = 0;

  always @(negedge video_rgb_clock)
    if (mode_change === 1'b1) mc_seen++;

  // reference model state
  int m_state, m_valid, m_field1, m_lace, m_res, m_ap, m_al;
  int m_prev_par, m_cand_lace, m_cand_res, m_stab;
  int m_last_act, m_lines, m_hsf, m_pending, exp_mc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int res_of(input int act);
    if (act <= LORES_MAX) return 0;
    if (act <= HIRES_MAX) return 1;
    return 2;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_valid = 0; m_field1 = 0; m_lace = 0; m_res = 0;
    m_ap = 0; m_al = 0; m_prev_par = 0; m_cand_lace = 0; m_cand_res = 0;
    m_stab = 0; m_last_act = 0; m_lines = 0; m_hsf = 0; m_pending = 0;
  endtask

  task automatic model_hs_fall(input bit with_vs);
    if (m_pending > 0) begin
      m_last_act = m_pending;
      m_lines++;
    end
    m_pending = 0;
    if (!with_vs) begin
      m_hsf++;
      if (m_hsf >= VS_TIMEOUT) begin
        m_state = M_IDLE;
        m_valid = 0;
      end
    end
  endtask

  task automatic model_vs_fall(input int phase, input int len);
    int parity, lace_c, new_res;
    parity  = (phase != 0 && phase >= len / 2) ? 1 : 0;
    lace_c  = (parity != m_prev_par) ? 1 : 0;
    m_prev_par = parity;
    new_res = (m_last_act != 0) ? res_of(m_last_act) : m_cand_res;
    if (lace_c == m_cand_lace && new_res == m_cand_res) m_stab++;
    else m_stab = 1;
    m_cand_lace = lace_c;
    m_cand_res  = new_res;
    if (m_state == M_IDLE) begin
      m_state = M_ACQ;
    end else if (m_state == M_ACQ) begin
      if (m_stab >= STABLE_FRAMES) begin
        m_state = M_LOCK; m_valid = 1;
        m_field1 = parity; m_ap = m_last_act; m_al = m_lines;
        m_lace = lace_c; m_res = new_res; exp_mc++;
      end
    end else begin
      m_field1 = parity; m_ap = m_last_act; m_al = m_lines;
      if (m_stab >= STABLE_FRAMES && (lace_c != m_lace || new_res != m_res)) begin
        m_lace = lace_c; m_res = new_res; exp_mc++;
      end
    end
    m_hsf   = 0;
    m_lines = 0;
  endtask

  // vs_mode: 0 low, 1 high, 2 falls with hs, 3 falls half a line after hs
  task automatic run_line(input int len, input int width, input bit vb,
                          input int vs_mode, input bit dropout);
    int cnt = 0;
    for (int c = 0; c < len; c++) begin
      @(negedge video_rgb_clock);
      hs     = (c < HS_W);
      hblank = !(c >= HB_END && c < HB_END + width);
      vblank = vb;
      case (vs_mode)
        1:       vs = 1'b1;
        2:       vs = (c < HS_W);
        3:       vs = (c < HS_W + len / 2);
        default: vs = 1'b0;
      endcase
      if (!hblank && !vblank) ce_pix = dropout ? ($urandom % 8 != 0) : 1'b1;
      else                    ce_pix = 1'($urandom % 2);
      if (ce_pix && !hblank && !vblank) cnt++;
      if (c == HS_W) begin
        model_hs_fall(vs_mode == 2);
        if (vs_mode == 2) model_vs_fall(0, len);
      end
      if (vs_mode == 3 && c == HS_W + len / 2) model_vs_fall(len / 2, len);
    end
    m_pending = cnt;
    check("mode_valid", mode_valid, m_valid);
  endtask

  task automatic check_frame();
    check("field1", field1, m_field1);
    check("lace", lace, m_lace);
    check("res", res, m_res);
    check("active_pixels", active_pixels, m_ap);
    check("active_lines", active_lines, m_al);
    check("mode_change_count", mc_seen, exp_mc);
  endtask

  function automatic int rand_len();
    return 136 + 2 * int'($urandom % 11);
  endfunction

  task automatic run_frame(input int width, input bit half, input bit dropout);
    int len, nl;
    len = rand_len();
    nl  = 10 + int'($urandom % 5);
    for (int l = 0; l < nl; l++) begin
      run_line(len, width, l < VB_LINES, (l < 2) ? 1 : (l == 2) ? (half ? 3 : 2) : 0, dropout);
      if (l == 2) check_frame();
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge video_rgb_clock);
    reset = 1'b1; hs = 1'b1; vs = 1'b0; hblank = 1'b1; vblank = 1'b1; ce_pix = 1'b0;
    repeat (cycles) @(negedge video_rgb_clock);
    model_reset();
    check("rst_mode_valid", mode_valid, 0);
    check("rst_res", res, 0);
    check("rst_lace", lace, 0);
    check("rst_field1", field1, 0);
    check("rst_active_pixels", active_pixels, 0);
    check("rst_active_lines", active_lines, 0);
    check("rst_mode_change", mode_change, 0);
    check("rst_mc_count", mc_seen, exp_mc);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w, sel;
    exp_mc = 0;
    model_reset();
    do_reset(5);

    // progressive lores
    for (int f = 0; f < 3; f++) run_frame(32, 1'b0, 1'b0);
    check("lores_locked", mode_valid, 1);
    check("lores_single_change", mc_seen, 1);

    // interlace: alternate phase 0 / half line
    for (int f = 0; f < 4; f++) run_frame(32, f % 2 == 0, 1'b0);

    // back to progressive, then resolution switch to hires
    for (int f = 0; f < 2; f++) run_frame(32, 1'b0, 1'b0);
    for (int f = 0; f < 3; f++) run_frame(64, 1'b0, 1'b0);

    // single shres glitch frame between hires frames
    run_frame(100, 1'b0, 1'b0);
    for (int f = 0; f < 2; f++) run_frame(64, 1'b0, 1'b0);

    // vs stops: lock must drop on the VS_TIMEOUT-th hs fall, mode held
    for (int l = 0; l < VS_TIMEOUT + 4; l++) run_line(rand_len(), 64, 1'b0, 0, 1'b0);
    check("timeout_res_hold", res, m_res);
    check("timeout_lace_hold", lace, m_lace);
    for (int f = 0; f < 3; f++) run_frame(64, 1'b0, 1'b0);

    // randomized frames including class boundaries
    for (int f = 0; f < 8; f++) begin
      sel = int'($urandom % 7);
      case (sel)
        0: w = LORES_MAX;
        1: w = LORES_MAX + 1;
        2: w = HIRES_MAX;
        3: w = HIRES_MAX + 1;
        4: w = 20 + int'($urandom % 21);
        5: w = 50 + int'($urandom % 27);
        default: w = 88 + int'($urandom % 13);
      endcase
      run_frame(w, 1'($urandom % 2), sel >= 4 && ($urandom % 2 == 1));
    end

    // mid-frame reset after relocking
    for (int f = 0; f < 2; f++) run_frame(32, 1'b0, 1'b0);
    run_line(rand_len(), 32, 1'b0, 0, 1'b0);
    do_reset(1);
    for (int f = 0; f < 3; f++) run_frame(64, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
